// File: rtl/ram_fifo.sv
// Synchronous FIFO over an inferred block-RAM array with a one-cycle registered read.
// Status flags decode from the registered count; overflow/underflow are sticky until rst.
module ram_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int ALMOST_FULL  = (1 << ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // No bypass: an empty FIFO rejects a same-cycle read, a full one a same-cycle write.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Memory has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      rd_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo.sv
// Directed and randomised checks of ram_fifo at DEPTH=4, ALMOST_FULL=3, ALMOST_EMPTY=1.
module tb_ram_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  ram_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_FULL(3), .ALMOST_EMPTY(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_err_flags got=%b%b exp=00", overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      step();
      total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      total++; if (almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
      total++; if (full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
      total++; if (almost_empty !== (i == 0)) begin bad++; $display("FAIL fill_almost_empty[%0d] got=%b exp=%b", i, almost_empty, i == 0); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, rd_valid); end
      total++; if (rd_data !== vals[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, vals[i]); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_valid_drop got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'h44) begin bad++; $display("FAIL drain_data_hold got=%h exp=44", rd_data); end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_no_underflow got=%b exp=0", underflow); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      total++; if (rd_data !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, rd_data, 8'hA0 + 8'(i)); end
    end
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b exp=0", rd_valid); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", underflow); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
    step();
    step();
    total++; if (overflow !== 1'b1 || underflow !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b%b exp=11", overflow, underflow);
    end
    do_reset();
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%b%b exp=00", overflow, underflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h01; step();
    wr_data = 8'h02; step();
    // Stream i pushes 3+i and pops 1+i, so the FIFO stays at two entries.
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(3 + i);
      step();
      total++; if (count !== 3'd2) begin bad++; $display("FAIL sim_count[%0d] got=%0d exp=2", i, count); end
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(1 + i)) begin
        bad++; $display("FAIL sim_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(1 + i));
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (rd_data !== 8'(11 + i)) begin bad++; $display("FAIL sim_tail[%0d] got=%h exp=%h", i, rd_data, 8'(11 + i)); end
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    step();
    total++; if (count !== 3'd1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL sim_empty got=%0d/%b exp=1/0", count, rd_valid);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h78 + 8'(i);
      step();
    end
    total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL sim_full_pre got=%b/%b exp=1/0", full, overflow); end
    rd_en = 1'b1; wr_data = 8'h7B;
    step();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL sim_full_count got=%0d exp=3", count); end
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin bad++; $display("FAIL sim_full_read got=%b/%h exp=1/77", rd_valid, rd_data); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sim_full_ovf got=%b exp=1", overflow); end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rd_data !== 8'h78 + 8'(i)) begin bad++; $display("FAIL sim_full_drain[%0d] got=%h exp=%h", i, rd_data, 8'h78 + 8'(i)); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL sim_final_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h31 + 8'(i);
      step();
    end
    wr_en = 1'b0; rst = 1'b1; rd_en = 1'b1;
    step();
    rst = 1'b0; rd_en = 1'b0;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst_count got=%0d/%b exp=0/1", count, empty); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", rd_valid); end
    wr_en = 1'b1; wr_data = 8'h99;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h99) begin bad++; $display("FAIL mid_rst_read got=%b/%h exp=1/99", rd_valid, rd_data); end
  endtask

  task automatic test_soak();
    logic [7:0] q [$];
    logic [7:0] exp_data;
    logic       wacc;
    logic       racc;
    do_reset();
    exp_data = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      wacc = wr_en && (q.size() < 4);
      racc = rd_en && (q.size() > 0);
      if (racc) exp_data = q.pop_front();
      if (wacc) q.push_back(wr_data);
      step();
      total++; if (count !== 3'(q.size())) begin bad++; $display("FAIL soak_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      total++; if (rd_valid !== racc) begin bad++; $display("FAIL soak_valid[%0d] got=%b exp=%b", i, rd_valid, racc); end
      if (racc) begin
        total++; if (rd_data !== exp_data) begin bad++; $display("FAIL soak_data[%0d] got=%h exp=%h", i, rd_data, exp_data); end
      end
      total++; if ({empty, full, almost_empty, almost_full} !==
                   {q.size() == 0, q.size() == 4, q.size() <= 1, q.size() >= 3}) begin
        bad++; $display("FAIL soak_flags[%0d] got=%b%b%b%b size=%0d", i, empty, full, almost_empty, almost_full, q.size());
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_reset_midstream();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo.md
# ram_fifo

Parametrised synchronous FIFO built on an inferred block-RAM array. It buffers a write stream into a power-of-two-deep memory and returns entries in order with the same one-cycle registered read latency as the single-port `ram` primitive. It also provides occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between producer and consumer logic in one clock domain, such as UART byte streams or pixel lines.

## Interface
- DATA_WIDTH, 16: entry width in bits.
- ADDR_WIDTH, 8: log2 of depth; DEPTH = 1 << ADDR_WIDTH.
- ALMOST_FULL, DEPTH-4: `almost_full` asserts when count >= this value.
- ALMOST_EMPTY, 4: `almost_empty` asserts when count <= this value.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data holds a newly popped entry.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= ALMOST_EMPTY.
- almost_full  out  1  count >= ALMOST_FULL.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

## Operation
- State:
  - wptr and rptr, each ADDR_WIDTH bits, wrapping modulo DEPTH.
  - count register, ADDR_WIDTH+1 bits.
  - memory array of DEPTH x DATA_WIDTH.
  - rd_data and rd_valid registers.
  - overflow and underflow registers.
- Write acceptance: wr_acc = wr_en & ~full. When accepted, mem[wptr] <= wr_data and wptr <= wptr+1.
- Read acceptance: rd_acc = rd_en & ~empty. When accepted, rd_data <= mem[rptr], rptr <= rptr+1, rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- Count update: count <= count + wr_acc - rd_acc.
  - Both accepted: count is unchanged.
  - No simultaneous-op bypass. When empty, a read in the same cycle as a write is rejected and the write is accepted. When full, a write in the same cycle as a read is rejected and the read is accepted.
- Flag derivation: empty, full, almost_empty and almost_full are decoded combinationally from the registered count only. They are never decoded from wr_en or rd_en.
- Error flags:
  - overflow <= 1 when wr_en & full.
  - underflow <= 1 when rd_en & empty.
  - Both clear only on rst.
- Reset:
  - Pointers and count go to 0, so empty=1 and almost_empty=1.
  - full=0 and almost_full=0 (given ALMOST_FULL > 0).
  - rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - rst has priority over wr_en/rd_en asserted in the same cycle; neither access takes effect.
- Pointer wrap: wptr and rptr wrap from DEPTH-1 to 0 with no special handling. Full versus empty is resolved by count, not by pointer comparison.

## Timing
- Write to visibility: write accepted at edge N, so count, empty and the flags reflect it after edge N. The earliest accepted read is in cycle N+1, and its data appears on rd_data with rd_valid=1 after edge N+1.
- Read latency: exactly 1 cycle from an accepted rd_en to rd_data/rd_valid, the same as the `ram` primitive.
- Back-to-back throughput: one write and one read per cycle sustained indefinitely at any count from 1 to DEPTH-1.
- Flag latency: every status output changes in the cycle after the accepted access that causes the change.
- Mid-operation reset: rst during streaming drops all stored entries. rd_valid is 0 in the cycle after rst, even if rd_en was high in the rst cycle.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), ALMOST_FULL=3, ALMOST_EMPTY=1.
- **Reset values:** rst for 2 cycles, then idle → count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0x00, overflow=0, underflow=0.
- **Fill and drain:**
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → almost_full=1 after the 3rd write; full=1 and count=4 after the 4th.
  - Then rd_en for 4 cycles → rd_data reads 0x11, 0x22, 0x33, 0x44, each with rd_valid=1 one cycle after its rd_en; empty=1 at the end.
- **Overflow/underflow:**
  - With full, assert wr_en(0x55) → write ignored, count stays 4, overflow=1.
  - Drain, then rd_en while empty → rd_valid=0, underflow=1.
  - Both flags stay at 1 until rst.
- **Simultaneous access:**
  - At count=2, wr_en and rd_en together for 10 cycles → count stays 2, data stays in order, pointers wrap with no loss.
  - At empty, wr_en+rd_en → count=1, rd_valid=0.
  - At full, wr_en+rd_en → count=3, write dropped, overflow=1.
- **Reset mid-stream:**
  - Assert rst with count=3 and rd_en=1 → next cycle count=0, empty=1, rd_valid=0.
  - Then write 0x99 and read → rd_data=0x99.
- **Wrap-around soak:** random wr_en/rd_en for 2000 cycles, compared against a reference queue → every rd_valid beat matches, and count always equals the model occupancy.
